// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined leading/trailing-zero counter with valid/ready handshake.
// A 2-bit encode of every input bit pair feeds a pairwise merge tree with a
// register after every merge level, followed by a registered output stage.
// This gives $clog2(N) register stages in total. A sideband tag travels
// alongside each word. A downstream stall freezes every stage together, so
// bubbles are held in place rather than squeezed out.
module lzc_pipe #(
   parameter int N     = 32,
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        in_data,
   input  logic                in_tz,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [$clog2(N):0]  out_count,
   output logic                out_zero,
   output logic [TAG_W-1:0]    out_tag
);
   localparam int L  = $clog2(N);
   localparam int CW = L + 1;

   logic          w_stall;
   logic [N-1:0]  w_rev;
   logic [N-1:0]  w_enc;

   // Output holds a result the consumer has not taken: freeze the whole pipe
   assign w_stall  = out_valid & ~out_ready;
   assign in_ready = ~w_stall;

   // Trailing-zero mode reuses the leading-zero tree on the bit-reversed word
   always_comb begin
      w_rev = in_data;
      if (in_tz) begin
         for (int i = 0; i < N; i++) begin
            w_rev[i] = in_data[N-1-i];
         end
      end else begin
         w_rev = in_data;
      end
   end

   // Stage-0 encode: leading-zero count of each 2-bit pair, MSB flags all-zero
   always_comb begin
      w_enc = '0;
      for (int j = 0; j < N/2; j++) begin
         case (w_rev[2*j+1 -: 2])
            2'b00:   w_enc[2*j +: 2] = 2'b10;
            2'b01:   w_enc[2*j +: 2] = 2'b01;
            default: w_enc[2*j +: 2] = 2'b00;
         endcase
      end
   end

   // Level k holds N>>(k+1) fields of k+2 bits; level 0 is the comb encode.
   // The last level always reduces to a single CW-bit field.
   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int FW = k + 2;
      localparam int NF = N >> (k + 1);

      logic [NF*FW-1:0]  w_fld;
      logic              w_vld;
      logic [TAG_W-1:0]  w_tag;

      if (k == 0) begin : g_enc
         assign w_fld = w_enc;
         assign w_vld = in_valid;
         assign w_tag = in_tag;
      end else begin : g_mrg
         localparam int PW = FW - 1;

         logic [NF*FW-1:0]  w_mrg;
         logic [NF*FW-1:0]  r_fld;
         logic              r_vld;
         logic [TAG_W-1:0]  r_tag;

         // Merge each left/right pair of the previous level into one wider count
         always_comb begin : p_merge
            logic [PW-1:0] w_l;
            logic [PW-1:0] w_r;
            w_mrg = '0;
            w_l   = '0;
            w_r   = '0;
            for (int j = 0; j < NF; j++) begin
               w_l = g_lvl[k-1].w_fld[(2*j+1)*PW +: PW];
               w_r = g_lvl[k-1].w_fld[(2*j)*PW +: PW];
               if (w_l[PW-1] & w_r[PW-1]) begin
                  w_mrg[j*FW +: FW] = {1'b1, {PW{1'b0}}};
               end else if (!w_l[PW-1]) begin
                  w_mrg[j*FW +: FW] = {2'b00, w_l[PW-2:0]};
               end else begin
                  w_mrg[j*FW +: FW] = {2'b01, w_r[PW-2:0]};
               end
            end
         end

         // Level register with valid and tag; holds its contents while stalled
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_vld <= 1'b0;
               r_fld <= '0;
               r_tag <= '0;
            end else if (!w_stall) begin
               r_vld <= g_lvl[k-1].w_vld;
               r_fld <= w_mrg;
               r_tag <= g_lvl[k-1].w_tag;
            end
         end

         assign w_fld = r_fld;
         assign w_vld = r_vld;
         assign w_tag = r_tag;
      end
   end

   // Registered output stage; the count MSB flags an all-zero input word
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_count <= '0;
         out_zero  <= 1'b0;
         out_tag   <= '0;
      end else if (!w_stall) begin
         out_valid <= g_lvl[L-1].w_vld;
         out_count <= g_lvl[L-1].w_fld;
         out_zero  <= g_lvl[L-1].w_fld[CW-1];
         out_tag   <= g_lvl[L-1].w_tag;
      end
   end

endmodule

// File: tb/tb_lzc_pipe.sv
// tb_lzc_pipe: self-checking bench for lzc_pipe at N = 2, 8, 32 and 64.
// Each width runs its own driver, ready generator and output monitor.
// Results are compared in order against a bit-scanning reference model.
module tb_lzc_pipe;

   typedef struct {
      int         cnt;
      logic [3:0] tag;
   } exp_t;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < 4; gi++) begin : g_inst
      localparam int NW = (gi == 0) ? 2 : (gi == 1) ? 8 : (gi == 2) ? 32 : 64;
      localparam int L  = $clog2(NW);

      logic           rst;
      logic           in_valid;
      logic           in_ready;
      logic [NW-1:0]  in_data;
      logic           in_tz;
      logic [3:0]     in_tag;
      logic           out_valid;
      logic           out_ready;
      logic [L:0]     out_count;
      logic           out_zero;
      logic [3:0]     out_tag;
      bit             done;
      bit             rnd_ready;
      string          pfx;
      exp_t           q[$];

      lzc_pipe #(.N(NW), .TAG_W(4)) u_dut (
         .clk       (clk),
         .reset     (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_data   (in_data),
         .in_tz     (in_tz),
         .in_tag    (in_tag),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out_count (out_count),
         .out_zero  (out_zero),
         .out_tag   (out_tag)
      );

      // Reference: scan from the counting end until the first set bit
      function automatic int ref_count(input logic [NW-1:0] d, input logic tz);
         int n = 0;
         if (tz) begin
            while (n < NW && d[n] == 1'b0) n++;
         end else begin
            while (n < NW && d[NW-1-n] == 1'b0) n++;
         end
         return n;
      endfunction

      function automatic logic [NW-1:0] one_hot(input int i);
         logic [NW-1:0] d = '0;
         d[i] = 1'b1;
         return d;
      endfunction

      function automatic logic [NW-1:0] rnd_word();
         logic [63:0]   w = {$urandom, $urandom};
         logic [NW-1:0] d = w[NW-1:0];
         return d >> $urandom_range(0, NW);
      endfunction

      // Offer one word and wait (bounded) until it is taken
      task automatic push(input logic [NW-1:0] d, input logic tz, input logic [3:0] tg);
         int b = 0;
         in_valid = 1'b1;
         in_data  = d;
         in_tz    = tz;
         in_tag   = tg;
         @(negedge clk);
         while (!in_ready && b < 200) begin
            b++;
            @(negedge clk);
         end
         check_eq({pfx, "accept"}, in_ready, 1'b1);
         @(posedge clk);
         #1;
      endtask

      // Single word into an idle pipe: latency and result checked directly
      task automatic lat_test(input logic [NW-1:0] d, input logic tz, input logic [3:0] tg,
                              input int expc, input string nm);
         int lat = 0;
         in_valid = 1'b1;
         in_data  = d;
         in_tz    = tz;
         in_tag   = tg;
         @(negedge clk);
         check_eq({pfx, nm, "_rdy"}, in_ready, 1'b1);
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         do begin
            @(negedge clk);
            lat++;
         end while (!out_valid && lat < 100);
         check_eq({pfx, nm, "_lat"}, lat, L);
         check_eq({pfx, nm, "_cnt"}, out_count, expc);
         check_eq({pfx, nm, "_zero"}, out_zero, (expc == NW));
         check_eq({pfx, nm, "_tag"}, out_tag, tg);
         @(posedge clk);
         #1;
      endtask

      task automatic drain();
         int b = 0;
         while (q.size() != 0 && b < 1000) begin
            @(negedge clk);
            b++;
         end
         check_eq({pfx, "drain"}, q.size(), 0);
         @(posedge clk);
         #1;
      endtask

      // Pseudo-random consumer back-pressure with a guaranteed 3-cycle low run
      initial begin : rdy_gen
         int cyc = 0;
         forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) begin
               cyc++;
               if ((cyc % 12) >= 4 && (cyc % 12) < 7) out_ready = 1'b0;
               else out_ready = (($urandom % 3) != 0);
            end
         end
      end

      // Output monitor: handshake rules, hold-while-stalled, in-order scoreboard
      initial begin : mon
         exp_t       e;
         bit         pst = 1'b0;
         logic [L:0] pc  = '0;
         logic [3:0] pt  = '0;
         logic       pz  = 1'b0;
         forever begin
            @(negedge clk);
            if (rst) begin
               q.delete();
               pst = 1'b0;
            end else begin
               check_eq({pfx, "in_ready"}, in_ready, !(out_valid && !out_ready));
               if (pst) begin
                  check_eq({pfx, "hold_vld"}, out_valid, 1'b1);
                  check_eq({pfx, "hold_cnt"}, out_count, pc);
                  check_eq({pfx, "hold_zero"}, out_zero, pz);
                  check_eq({pfx, "hold_tag"}, out_tag, pt);
               end
               if (out_valid && out_ready) begin
                  check_eq({pfx, "out_expected"}, (q.size() > 0), 1'b1);
                  if (q.size() > 0) begin
                     e = q.pop_front();
                     check_eq({pfx, "sb_cnt"}, out_count, e.cnt);
                     check_eq({pfx, "sb_zero"}, out_zero, (e.cnt == NW));
                     check_eq({pfx, "sb_tag"}, out_tag, e.tag);
                  end
               end
               if (in_valid && in_ready) begin
                  q.push_back('{ref_count(in_data, in_tz), in_tag});
               end
               pst = out_valid && !out_ready;
               pc  = out_count;
               pt  = out_tag;
               pz  = out_zero;
            end
         end
      end

      // Test sequence for this width
      initial begin : drv
         pfx       = $sformatf("N%0d_", NW);
         done      = 1'b0;
         rnd_ready = 1'b0;
         rst       = 1'b1;
         in_valid  = 1'b0;
         in_data   = '0;
         in_tz     = 1'b0;
         in_tag    = 4'd0;
         out_ready = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         check_eq({pfx, "rst_vld"}, out_valid, 1'b0);
         check_eq({pfx, "rst_cnt"}, out_count, 0);
         check_eq({pfx, "rst_zero"}, out_zero, 1'b0);
         check_eq({pfx, "rst_tag"}, out_tag, 0);
         rst = 1'b0;
         @(posedge clk);
         #1;
         check_eq({pfx, "rst_rdy"}, in_ready, 1'b1);

         // Directed corner words
         lat_test(one_hot(NW/2), 1'b0, 4'd3, NW/2 - 1, "mid_lz");
         lat_test(one_hot(NW/2), 1'b1, 4'd5, NW/2, "mid_tz");
         lat_test(one_hot(NW-1), 1'b0, 4'd6, 0, "msb_lz");
         lat_test(one_hot(0), 1'b1, 4'd9, 0, "lsb_tz");
         lat_test('0, 1'b0, 4'd10, NW, "zero_lz");
         lat_test('0, 1'b1, 4'd12, NW, "zero_tz");

         // One-hot sweep in both modes
         for (int i = 0; i < NW; i++) begin
            lat_test(one_hot(i), 1'b0, 4'(i), NW - 1 - i, "hot_lz");
            lat_test(one_hot(i), 1'b1, 4'(i + 1), i, "hot_tz");
         end

         // Back-to-back random stream under random back-pressure
         rnd_ready = 1'b1;
         for (int i = 0; i < 16; i++) begin
            push(rnd_word(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         end
         in_valid = 1'b0;
         drain();
         rnd_ready = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1;

         // Reset with four words in flight
         for (int i = 0; i < 4; i++) begin
            push(rnd_word() | one_hot(0), 1'b0, 4'(i + 1));
         end
         in_valid = 1'b0;
         rst      = 1'b1;
         #1;
         check_eq({pfx, "mid_rst_vld"}, out_valid, 1'b0);
         check_eq({pfx, "mid_rst_tag"}, out_tag, 0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         check_eq({pfx, "post_rst_rdy"}, in_ready, 1'b1);
         lat_test(one_hot(NW-1) | one_hot(0), 1'b1, 4'd14, 0, "after_rst");
         repeat (L + 2) @(posedge clk);
         #1;
         check_eq({pfx, "after_rst_idle"}, out_valid, 1'b0);
         done = 1'b1;
      end
   end

   initial begin : main
      int c = 0;
      while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done && g_inst[3].done)
             && c < 60000) begin
         @(posedge clk);
         c++;
      end
      check_eq("all_done", (c < 60000), 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
